// File: rtl/ram_cart_ctl.sv
// Mega CD backup-RAM cartridge controller: decodes 68k cart space (size reg, RAM window, WEN reg),
// packs cart bytes two per SRAM word and scans a dirty-block bitmap for the host MCU to flush.
module ram_cart_ctl #(
  parameter int MEM_AW   = 18,
  parameter int MEM_LAT  = 2,
  parameter int SIZE_MAX = 6,
  parameter int BLK_AW   = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cart_on,
  input  logic [2:0]               size,
  input  logic [23:0]              cpu_addr,
  input  logic [15:0]              cpu_dat,
  input  logic                     cpu_as,
  input  logic                     cpu_oe,
  input  logic                     cpu_we_lo,
  output logic [15:0]              cart_dout,
  output logic                     cart_oe,
  output logic [MEM_AW-1:0]        mem_addr,
  output logic [15:0]              mem_din,
  input  logic [15:0]              mem_dout,
  output logic                     mem_oe,
  output logic                     mem_we_hi,
  output logic                     mem_we_lo,
  output logic                     dirty_vld,
  output logic [MEM_AW-BLK_AW:0]   dirty_blk,
  input  logic                     dirty_ack,
  output logic [2:0]               dbg_state
);

  localparam int IW = MEM_AW + 1;           // cart byte index width
  localparam int BW = MEM_AW + 1 - BLK_AW;  // dirty block index width
  localparam int NBLK = 1 << BW;
  localparam logic [2:0] SMAX = 3'(SIZE_MAX);
  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);
  localparam logic [3:0] REG_SIZE = 4'h4;
  localparam logic [3:0] REG_RAM  = 4'h6;
  localparam logic [3:0] REG_WEN  = 4'h7;

  typedef enum logic [2:0] {IDLE, WAIT_STB, RD, HOLD, WR, DONE} state_t;

  state_t          state, state_n;
  logic            as_r, as_p;
  logic [2:0]      lat_cnt;
  logic [IW-1:0]   idx_q;
  logic [3:0]      region_q;
  logic [7:0]      dat_q;
  logic            wen;
  logic [NBLK-1:0] dirty;
  logic [BW-1:0]   ptr;

  logic [2:0]      size_eff;
  logic [IW:0]     cap_bytes, cap_m1;
  logic [IW-1:0]   idx_mask, cpu_idx;
  logic [BW-1:0]   last_blk, wr_blk;
  logic            start, latch, wr_set, scan_hit, ack_clr;

  assign size_eff  = (size > SMAX) ? SMAX : size;
  assign cap_bytes = (IW+1)'(1) << (13 + int'(size_eff));
  assign cap_m1    = cap_bytes - (IW+1)'(1);
  assign idx_mask  = cap_m1[IW-1:0];
  assign last_blk  = idx_mask[IW-1:BLK_AW];
  assign cpu_idx   = cpu_addr[IW:1] & idx_mask;

  // Bus handshake: a cycle opens on the registered falling edge of cpu_as and closes when the
  // registered cpu_as is seen high; cart_dout is valid to the bus only while cart_oe=1.
  assign start = as_p & ~as_r & cart_on;

  always_comb begin
    state_n   = state;
    mem_oe    = 1'b0;
    mem_we_hi = 1'b0;
    mem_we_lo = 1'b0;
    cart_oe   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (!cpu_oe)         state_n = RD;
          else if (!cpu_we_lo) state_n = WR;
          else                 state_n = WAIT_STB;
        end
      end
      WAIT_STB: begin
        if (as_r)            state_n = IDLE;
        else if (!cpu_oe)    state_n = RD;
        else if (!cpu_we_lo) state_n = WR;
      end
      RD: begin
        // A RAM read always runs its full latency, even if the CPU has already let go of as.
        if (region_q == REG_RAM) begin
          mem_oe = 1'b1;
          if (lat_cnt == LAT_LAST) state_n = HOLD;
        end else if (region_q == REG_SIZE || region_q == REG_WEN) begin
          state_n = HOLD;
        end else begin
          state_n = DONE;
        end
      end
      HOLD: begin
        cart_oe = ~cpu_oe & ~cpu_as & cart_on;
        if (as_r) state_n = IDLE;
      end
      WR: begin
        if (region_q == REG_RAM && wen) begin
          mem_we_hi = ~idx_q[0];
          mem_we_lo = idx_q[0];
        end
        state_n = DONE;
      end
      DONE: begin
        if (as_r) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign latch    = (state == IDLE || state == WAIT_STB) && (state_n == RD || state_n == WR);
  assign wr_set   = (state == WR) && (region_q == REG_RAM) && wen;
  assign wr_blk   = idx_q[IW-1:BLK_AW];
  assign scan_hit = dirty[ptr] && (ptr <= last_blk);
  assign ack_clr  = dirty_ack && scan_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      as_r      <= 1'b1;
      as_p      <= 1'b1;
      lat_cnt   <= '0;
      idx_q     <= '0;
      region_q  <= '0;
      dat_q     <= '0;
      wen       <= 1'b0;
      cart_dout <= '0;
      dirty     <= '0;
      ptr       <= '0;
    end else begin
      state   <= state_n;
      as_r    <= cpu_as;
      as_p    <= as_r;
      lat_cnt <= (state == RD && mem_oe) ? 3'(lat_cnt + 3'd1) : 3'd0;
      if (latch) begin
        idx_q    <= cpu_idx;
        region_q <= cpu_addr[23:20];
        dat_q    <= cpu_dat[7:0];
      end
      if (state == RD) begin
        if (region_q == REG_RAM && lat_cnt == LAT_LAST)
          cart_dout <= {8'hFF, idx_q[0] ? mem_dout[7:0] : mem_dout[15:8]};
        else if (region_q == REG_SIZE)
          cart_dout <= {8'hFF, 5'b0, size_eff};
        else if (region_q == REG_WEN)
          cart_dout <= {15'b0, wen};
      end
      if (state == WR && region_q == REG_WEN) wen <= dat_q[0];
      // Set is applied after clear so a same-clock write keeps the block dirty.
      if (ack_clr) dirty[ptr] <= 1'b0;
      if (wr_set)  dirty[wr_blk] <= 1'b1;
      if (!scan_hit) ptr <= (ptr >= last_blk) ? '0 : ptr + BW'(1);
    end
  end

  assign mem_addr  = idx_q[IW-1:1];
  assign mem_din   = {dat_q, dat_q};
  assign dirty_vld = scan_hit;
  assign dirty_blk = ptr;
  assign dbg_state = state;

  logic unused_bits;
  assign unused_bits = &{1'b0, cpu_addr[0], cpu_dat[15:8], cap_m1[IW]};

endmodule

// File: doc/ram_cart_ctl.md
Name: ram_cart_ctl

Overview:
Parametrised Mega CD backup-RAM cartridge controller, the successor to the fixed-size cart logic used in the MCD mapper. It decodes the 68k cart-space accesses: size register, RAM window and write-enable register. Cart bytes are packed two per 16-bit word in external SRAM/PSRAM, with a configurable memory latency. It also tracks dirty blocks so the host MCU can flush only modified regions to SD.

Parameters:
MEM_AW, 18, external memory word-address width (capacity 2^(MEM_AW+1) bytes)
MEM_LAT, 2, clocks from mem_oe assertion to valid mem_dout (1..7)
SIZE_MAX, 6, largest legal size code; capacity = 8KB << size
BLK_AW, 9, log2 of dirty-block size in cart bytes (512 B)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
cart_on  in  1  cartridge present; 0 = block fully invisible
size  in  3  runtime size code, clamped to SIZE_MAX
cpu_addr  in  24  68k byte address
cpu_dat  in  16  68k write data
cpu_as  in  1  address strobe, active-low
cpu_oe  in  1  read strobe, active-low
cpu_we_lo  in  1  low-byte (odd) write strobe, active-low
cart_dout  out  16  read data to bus
cart_oe  out  1  drive cart_dout onto bus
mem_addr  out  MEM_AW  word address
mem_din  out  16  write data {byte,byte}
mem_dout  in  16  read data
mem_oe  out  1  memory read enable
mem_we_hi  out  1  write even cart byte (hi lane)
mem_we_lo  out  1  write odd cart byte (lo lane)
dirty_vld  out  1  dirty_blk is valid
dirty_blk  out  MEM_AW+1-BLK_AW  lowest-found dirty block index
dirty_ack  in  1  one-clock pulse: clear the presented block

Behaviour:
- Reset: all outputs 0; wen=0; dirty bitmap all clear; FSM IDLE; scanner pointer 0.
- cpu_as is registered once; a bus cycle starts on the registered high->low edge. Decoding is ignored when cart_on=0.
- Regions by cpu_addr[23:20]:
  - 4 = size register; read returns {8'hFF, 5'b0, size_eff}.
  - 6 = RAM, odd bytes only; idx = cpu_addr[19:1] & (capacity-1); word = idx[MEM_AW:1]; lane = idx[0] (0 = hi, 1 = lo).
  - 7 = WEN register; bit0 written by any odd-byte write; read returns {15'b0, wen}.
- size_eff = min(size, SIZE_MAX).
- FSM states and transitions:
  - IDLE: on cycle start, go to RD if cpu_oe=0, WR if cpu_we_lo=0, else WAIT_STB.
  - WAIT_STB: re-evaluates the strobes every clock while as=0.
  - RD (RAM): mem_oe=1 for exactly MEM_LAT clocks. Latch the selected lane into cart_dout low byte, with the high byte = 8'hFF. Go to HOLD.
  - RD (register): load cart_dout in the same clock and go to HOLD.
  - HOLD: cart_oe=1 while cpu_oe=0 and as=0. Exit to IDLE on registered as high.
  - WR (RAM, wen=1): one clock with mem_din={dat[7:0],dat[7:0]} and the lane's we asserted. Set the dirty bit for block idx>>BLK_AW. Go to DONE.
  - WR (RAM, wen=0): no memory cycle, no dirty update.
  - DONE: wait for as high, then IDLE. One write per bus cycle.
- Even-byte writes (cpu_we_lo=1) are ignored. Writes to the size register are ignored.
- cart_oe is never asserted for addresses outside regions 4, 6 and 7.
- as rising mid-RD: the memory read completes (no truncated mem_oe) and cart_oe stays 0; return to IDLE.
- rst mid-operation aborts immediately. The write strobe drops; partial writes are not retried.
- Dirty scanner:
  - Pointer advances one block per clock over blocks < capacity>>BLK_AW and wraps to 0.
  - It stops on a set bit and presents it: dirty_vld=1, dirty_blk=pointer.
  - dirty_ack clears that bit and the pointer resumes next clock.
  - dirty_ack together with a CPU write to the same block in the same clock: the write wins and the bit stays set.
  - dirty_ack while dirty_vld=0 is ignored.
- A size change re-masks addressing immediately. Dirty bits beyond the new capacity are retained but not scanned.

Test Plan:
- Reset, then read $400001 with size=3 -> cart_dout=16'hFF03, cart_oe only while cpu_oe low.
- Write 8'h5A to $600001 with wen=0, then read it back -> no mem_we pulse; dirty_vld stays 0.
- Write $7FFFFF=1, then write 8'hA5 to $600003 -> mem_addr=0, mem_we_lo=1 for 1 clk, mem_din=16'hA5A5. Read $600003 -> mem_oe for MEM_LAT clocks, cart_dout=16'hFFA5. dirty_vld=1 with dirty_blk=0 within capacity>>BLK_AW clocks.
- size=0 (8KB), write to $604001 -> aliases idx 0 (mem_addr=0, hi lane). Write to the top block then dirty_ack -> bit clears; the next set block is presented.
- Same clock: dirty_ack for block 2 and a CPU write into block 2 -> block 2 is still reported dirty afterwards.
- Assert rst during an RD wait state -> all outputs 0 next edge; wen=0; the bitmap is empty.
